// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. one buffered
// long-latency result, with a starvation-forced single-cycle stall.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RFWEWin,
    input  logic        MtoRFSelWin,
    input  logic [31:0] DMOutWin,
    input  logic [31:0] ALUOutWin,
    input  logic [4:0]  RFAWin,
    input  logic        LLValid,
    input  logic [4:0]  LLAddr,
    input  logic [31:0] LLData,
    output logic        LLReady,
    output logic        LLDrop,
    output logic        StallPipe,
    output logic        RFWE,
    output logic [4:0]  RFWA,
    output logic [31:0] RFWD
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    logic [4:0]       buf_addr;
    logic [31:0]      buf_data;
    logic [CNT_W-1:0] count;

    logic             preq;
    logic [31:0]      pdata;
    logic [CNT_W-1:0] cnt_inc;

    assign preq      = RFWEWin && (RFAWin != 5'd0);
    assign pdata     = MtoRFSelWin ? DMOutWin : ALUOutWin;
    assign cnt_inc   = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
    assign LLReady   = (state == IDLE);
    assign StallPipe = (state == STALL);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            buf_addr <= 5'd0;
            buf_data <= 32'd0;
            count    <= '0;
            LLDrop   <= 1'b0;
            RFWE     <= 1'b0;
            RFWA     <= 5'd0;
            RFWD     <= 32'd0;
        end else begin
            RFWE   <= 1'b0;
            LLDrop <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (preq) begin
                        RFWE <= 1'b1;
                        RFWA <= RFAWin;
                        RFWD <= pdata;
                    end
                    // $0 results are consumed but never buffered
                    if (LLValid && (LLAddr != 5'd0)) begin
                        buf_addr <= LLAddr;
                        buf_data <= LLData;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (preq) begin
                        RFWE <= 1'b1;
                        RFWA <= RFAWin;
                        RFWD <= pdata;
                        // younger pipeline write supersedes the buffered one
                        if (RFAWin == buf_addr) begin
                            LLDrop <= 1'b1;
                            count  <= '0;
                            state  <= IDLE;
                        end else begin
                            count <= cnt_inc;
                            if (cnt_inc >= LIMIT) begin
                                state <= STALL;
                            end
                        end
                    end else begin
                        RFWE  <= 1'b1;
                        RFWA  <= buf_addr;
                        RFWD  <= buf_data;
                        count <= '0;
                        state <= IDLE;
                    end
                end
                STALL: begin
                    RFWE  <= 1'b1;
                    RFWA  <= buf_addr;
                    RFWD  <= buf_data;
                    count <= '0;
                    state <= IDLE;
                end
                default: begin
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
